// File: rtl/score_seg_encoder_if.sv
// score_seg_encoder_if: request/result bundle for the score display encoder.
//   start  - conversion request (block samples it only while idle)
//   score  - 14-bit unsigned binary score
//   busy   - conversion in progress
//   done   - one-cycle pulse when bcd/seg* carry a new result
//   bcd    - packed BCD result, [15:12] thousands .. [3:0] ones
//   seg3..seg0 - 7-segment patterns (index 0 = segment a) for
//                thousands, hundreds, tens, ones
// master: the requester side; slave: the encoder.
interface score_seg_encoder_if;
    logic        start;
    logic [13:0] score;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic [0:6]  seg3;
    logic [0:6]  seg2;
    logic [0:6]  seg1;
    logic [0:6]  seg0;

    modport master (
        output start, score,
        input  busy, done, bcd, seg3, seg2, seg1, seg0
    );

    modport slave (
        input  start, score,
        output busy, done, bcd, seg3, seg2, seg1, seg0
    );
endinterface

// File: rtl/score_seg_encoder.sv
// score_seg_encoder: saturates a binary score to MAX_SCORE, converts it to
// four BCD digits with a serial double-dabble (one bit per cycle) and
// registers the digits plus their 7-segment patterns. Start-to-done latency
// is a fixed 15 cycles.
// Ports:
//   clk   - clock, rising edge
//   rst_n - synchronous active-low reset
//   bus   - score_seg_encoder_if.slave (start/score in, busy/done/bcd/seg* out)
// Optional feature: define SCORE_LZ_BLANK_EN to blank leading-zero digits
// on seg3..seg1 (seg0 always shows its digit; bcd is never affected).
module score_seg_encoder #(
    parameter int MAX_SCORE = 9999
) (
    input  logic                  clk,
    input  logic                  rst_n,
    score_seg_encoder_if.slave    bus
);

    localparam logic [13:0] MAX_S    = 14'(MAX_SCORE);
    localparam logic [0:6]  SEG_ZERO = 7'b1111110;
    localparam logic [0:6]  SEG_BLNK = 7'b0000000;
`ifdef SCORE_LZ_BLANK_EN
    localparam logic [0:6]  SEG_RST_HI = SEG_BLNK;
`else
    localparam logic [0:6]  SEG_RST_HI = SEG_ZERO;
`endif

    typedef enum logic [1:0] {IDLE, CAPT, CONV, UPD} state_t;

    state_t      state, state_nxt;
    logic [13:0] bin;
    logic [15:0] acc, acc_adj;
    logic [3:0]  cnt;
    logic [13:0] score_sat;

    logic        busy, done;
    logic [15:0] bcd;
    logic [0:6]  seg3, seg2, seg1, seg0;
    logic [0:6]  p3, p2, p1, p0;

    function automatic logic [0:6] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'b1111110;
            4'd1:    seg_of = 7'b0110000;
            4'd2:    seg_of = 7'b1101101;
            4'd3:    seg_of = 7'b1111001;
            4'd4:    seg_of = 7'b0110011;
            4'd5:    seg_of = 7'b1011011;
            4'd6:    seg_of = 7'b1011111;
            4'd7:    seg_of = 7'b1110000;
            4'd8:    seg_of = 7'b1111111;
            4'd9:    seg_of = 7'b1111011;
            default: seg_of = 7'b0000000;
        endcase
    endfunction

    assign score_sat = (bus.score > MAX_S) ? MAX_S : bus.score;

    // Double-dabble correction: any digit >=5 would overflow past 9 on the shift.
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < 4; i++) begin
            if (acc[i*4 +: 4] >= 4'd5)
                acc_adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
        end
    end

    // Patterns from the finished accumulator; only consumed in UPD.
    always_comb begin
        p3 = seg_of(acc[15:12]);
        p2 = seg_of(acc[11:8]);
        p1 = seg_of(acc[7:4]);
        p0 = seg_of(acc[3:0]);
`ifdef SCORE_LZ_BLANK_EN
        if (acc[15:12] == 4'd0)                                   p3 = SEG_BLNK;
        if (acc[15:8]  == 8'd0)                                   p2 = SEG_BLNK;
        if (acc[15:4]  == 12'd0)                                  p1 = SEG_BLNK;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // IDLE captures directly into CONV so the latency stays at 15 cycles;
    // CAPT is only a recovery path into CONV.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = CONV;
            CAPT:    state_nxt = CONV;
            CONV:    if (cnt == 4'd13) state_nxt = UPD;
            UPD:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
            bcd  <= 16'h0000;
            seg3 <= SEG_RST_HI;
            seg2 <= SEG_RST_HI;
            seg1 <= SEG_RST_HI;
            seg0 <= SEG_ZERO;
            bin  <= '0;
            acc  <= '0;
            cnt  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    bin  <= score_sat;
                    acc  <= '0;
                    cnt  <= '0;
                    busy <= 1'b1;
                end
                CONV: begin
                    {acc, bin} <= {acc_adj[14:0], bin, 1'b0};
                    cnt        <= cnt + 4'd1;
                end
                UPD: begin
                    bcd  <= acc;
                    seg3 <= p3;
                    seg2 <= p2;
                    seg1 <= p1;
                    seg0 <= p0;
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.bcd  = bcd;
    assign bus.seg3 = seg3;
    assign bus.seg2 = seg2;
    assign bus.seg1 = seg1;
    assign bus.seg0 = seg0;

endmodule

// File: tb/tb_score_seg_encoder.sv
// Directed testbench for score_seg_encoder. Expected values are hand-derived
// digit patterns; leading-zero expectations follow SCORE_LZ_BLANK_EN.
module tb_score_seg_encoder;

    localparam logic [0:6] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101,
                           S3 = 7'b1111001, S4 = 7'b0110011, S5 = 7'b1011011,
                           S8 = 7'b1111111, S9 = 7'b1111011;
`ifdef SCORE_LZ_BLANK_EN
    localparam logic [0:6] LZ = 7'b0000000;
`else
    localparam logic [0:6] LZ = 7'b1111110;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    score_seg_encoder_if bus ();

    score_seg_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        bus.start = 1'b0;
        bus.score = 14'd0;
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b want 0", bus.done); end
        n_checks++; if (bus.bcd !== 16'h0000) begin n_fail++; $display("FAIL reset bcd: got %h want 0000", bus.bcd); end
        n_checks++; if (bus.seg0 !== S0) begin n_fail++; $display("FAIL reset seg0: got %b want %b", bus.seg0, S0); end
        n_checks++; if (bus.seg1 !== LZ) begin n_fail++; $display("FAIL reset seg1: got %b want %b", bus.seg1, LZ); end
        n_checks++; if (bus.seg2 !== LZ) begin n_fail++; $display("FAIL reset seg2: got %b want %b", bus.seg2, LZ); end
        n_checks++; if (bus.seg3 !== LZ) begin n_fail++; $display("FAIL reset seg3: got %b want %b", bus.seg3, LZ); end
        rst_n = 1'b1;
        tick();
    endtask

    // Table-driven single conversions: latency, hold, saturation, digits.
    task automatic test_conversions;
        logic [13:0] sc  [0:6];
        logic [15:0] eb  [0:6];
        logic [0:6]  e3  [0:6];
        logic [0:6]  e2  [0:6];
        logic [0:6]  e1  [0:6];
        logic [0:6]  e0  [0:6];
        logic [15:0] prev;
        int          lat;
        logic        seen;
        sc = '{14'd1234, 14'd16383, 14'd0, 14'd42, 14'd5008, 14'd9999, 14'd10000};
        eb = '{16'h1234, 16'h9999, 16'h0000, 16'h0042, 16'h5008, 16'h9999, 16'h9999};
        e3 = '{S1, S9, LZ, LZ, S5, S9, S9};
        e2 = '{S2, S9, LZ, LZ, S0, S9, S9};
        e1 = '{S3, S9, LZ, S4, S0, S9, S9};
        e0 = '{S4, S9, S0, S2, S8, S9, S9};
        for (int i = 0; i < 7; i++) begin
            prev = bus.bcd;
            bus.score = sc[i];
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL conv%0d busy_at_start: got %b want 1", i, bus.busy); end
            lat  = 0;
            seen = 1'b0;
            while (!seen && lat < 40) begin
                tick();
                lat++;
                if (lat == 3) bus.score = 14'd3333;
                if (lat == 7) begin
                    n_checks++; if (bus.bcd !== prev) begin n_fail++; $display("FAIL conv%0d hold_bcd: got %h want %h", i, bus.bcd, prev); end
                end
                if (bus.done === 1'b1) seen = 1'b1;
            end
            n_checks++; if (lat !== 15) begin n_fail++; $display("FAIL conv%0d latency: got %0d want 15", i, lat); end
            n_checks++; if (bus.bcd !== eb[i]) begin n_fail++; $display("FAIL conv%0d bcd: got %h want %h", i, bus.bcd, eb[i]); end
            n_checks++; if (bus.seg3 !== e3[i]) begin n_fail++; $display("FAIL conv%0d seg3: got %b want %b", i, bus.seg3, e3[i]); end
            n_checks++; if (bus.seg2 !== e2[i]) begin n_fail++; $display("FAIL conv%0d seg2: got %b want %b", i, bus.seg2, e2[i]); end
            n_checks++; if (bus.seg1 !== e1[i]) begin n_fail++; $display("FAIL conv%0d seg1: got %b want %b", i, bus.seg1, e1[i]); end
            n_checks++; if (bus.seg0 !== e0[i]) begin n_fail++; $display("FAIL conv%0d seg0: got %b want %b", i, bus.seg0, e0[i]); end
            n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL conv%0d busy_at_done: got %b want 0", i, bus.busy); end
            tick();
            n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL conv%0d done_width: got %b want 0", i, bus.done); end
        end
    endtask

    // Start ignored while busy, score change after capture ignored, start in
    // the done cycle accepted. c counts edges after the first accepted start.
    task automatic test_back_to_back;
        int          d1 = -1, d2 = -1, ndone = 0;
        logic [15:0] b1 = '0, b2 = '0;
        logic        busy16 = 1'b0;
        bus.score = 14'd42;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (bus.done === 1'b1) begin
                ndone++;
                if (d1 < 0) begin d1 = c; b1 = bus.bcd; end
                else if (d2 < 0) begin d2 = c; b2 = bus.bcd; end
            end
            if (c == 16) busy16 = bus.busy;
            if (c == 5) bus.score = 14'd7;
            bus.start = (c == 3) || (c == d1);
        end
        bus.start = 1'b0;
        n_checks++; if (d1 !== 15) begin n_fail++; $display("FAIL b2b first_done_cycle: got %0d want 15", d1); end
        n_checks++; if (b1 !== 16'h0042) begin n_fail++; $display("FAIL b2b first_bcd: got %h want 0042", b1); end
        n_checks++; if (busy16 !== 1'b1) begin n_fail++; $display("FAIL b2b restart_busy: got %b want 1", busy16); end
        n_checks++; if (d2 !== 31) begin n_fail++; $display("FAIL b2b second_done_cycle: got %0d want 31", d2); end
        n_checks++; if (b2 !== 16'h0007) begin n_fail++; $display("FAIL b2b second_bcd: got %h want 0007", b2); end
        n_checks++; if (ndone !== 2) begin n_fail++; $display("FAIL b2b done_count: got %0d want 2", ndone); end
    endtask

    task automatic test_reset_mid;
        int   ndone = 0;
        int   lat = 0;
        logic seen = 1'b0;
        bus.score = 14'd1234;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c < 8; c++) begin
            tick();
            if (bus.done === 1'b1) ndone++;
        end
        rst_n = 1'b0;
        tick();
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst busy: got %b want 0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL midrst done: got %b want 0", bus.done); end
        n_checks++; if (bus.bcd !== 16'h0000) begin n_fail++; $display("FAIL midrst bcd: got %h want 0000", bus.bcd); end
        n_checks++; if (bus.seg0 !== S0) begin n_fail++; $display("FAIL midrst seg0: got %b want %b", bus.seg0, S0); end
        n_checks++; if (bus.seg3 !== LZ) begin n_fail++; $display("FAIL midrst seg3: got %b want %b", bus.seg3, LZ); end
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.done === 1'b1) ndone++;
        end
        n_checks++; if (ndone !== 0) begin n_fail++; $display("FAIL midrst no_done: got %0d want 0", ndone); end
        bus.score = 14'd5008;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        while (!seen && lat < 40) begin
            tick();
            lat++;
            if (bus.done === 1'b1) seen = 1'b1;
        end
        n_checks++; if (lat !== 15) begin n_fail++; $display("FAIL midrst next_latency: got %0d want 15", lat); end
        n_checks++; if (bus.bcd !== 16'h5008) begin n_fail++; $display("FAIL midrst next_bcd: got %h want 5008", bus.bcd); end
    endtask

    initial begin
        test_reset();
        test_conversions();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
